// File: rtl/pico_sseg_bus_if.sv
// PicoRV32-style native bus between the CPU (master) and the segment encoder (slave).
// Request fields flow master->slave; ready/rdata flow back combinationally.
interface pico_sseg_bus_if;
    logic        busin_valid;
    logic [31:0] busin_addr;
    logic [31:0] busin_wdata;
    logic [3:0]  busin_wstrb;
    logic        busout_ready;
    logic [31:0] busout_rdata;

    modport master (
        output busin_valid,
        output busin_addr,
        output busin_wdata,
        output busin_wstrb,
        input  busout_ready,
        input  busout_rdata
    );

    modport slave (
        input  busin_valid,
        input  busin_addr,
        input  busin_wdata,
        input  busin_wstrb,
        output busout_ready,
        output busout_rdata
    );
endinterface

// File: rtl/pico_sseg_encoder.sv
// pico_sseg_encoder: converts a 16-bit bus-written value to four 7-segment bytes via double-dabble.
// Leading-zero blanking (CTRL[4]) is built only when SSEG_ENC_LZB_EN is defined.
module pico_sseg_encoder #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic                  clk,
    input  logic                  resetn,
    pico_sseg_bus_if.slave        bus,
    output logic [31:0]           seg_word,
    output logic                  seg_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_ENCODE = 2'd2;

    localparam logic [1:0] REG_VALUE  = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_SEG    = 2'd3;

    logic [1:0]  state_r;
    logic [4:0]  cnt_r;
    logic [15:0] bin_r;
    logic [19:0] bcd_r;
    logic [15:0] value_r;
    logic [3:0]  dp_r;
    logic        ovf_r;
    logic [31:0] seg_word_r;
    logic        seg_valid_r;
`ifdef SSEG_ENC_LZB_EN
    logic        lzb_r;
`endif

    logic        is_read_s;
    logic        is_write_s;
    logic        wr_value_s;
    logic        wr_ctrl_s;
    logic        start_s;
    logic        busy_s;
    logic        lzb_en_s;
    logic        ovf_next_s;
    logic [3:0]  blank_s;
    logic [4:0]  ctrl_s;
    logic [15:0] value_next_s;
    logic [19:0] bcd_adj_s;
    logic [31:0] seg_next_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hBF;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Overflow dashes take priority over blanking; dp is applied last so blanked digits keep it.
    function automatic logic [7:0] encode_byte(input logic [3:0] d, input logic ovf,
                                               input logic blank, input logic dp);
        logic [7:0] b;
        if (ovf) begin
            b = 8'hBF;
        end else if (blank) begin
            b = 8'hFF;
        end else begin
            b = digit_code(d);
        end
        return {b[7] & ~dp, b[6:0]};
    endfunction

    assign is_write_s = bus.busin_valid && (bus.busin_wstrb != 4'b0000);
    assign is_read_s  = bus.busin_valid && (bus.busin_wstrb == 4'b0000);
    assign wr_value_s = is_write_s && (bus.busin_addr[3:2] == REG_VALUE);
    assign wr_ctrl_s  = is_write_s && (bus.busin_addr[3:2] == REG_CTRL) && bus.busin_wstrb[0];
    assign start_s    = wr_value_s && (bus.busin_wstrb[1] || bus.busin_wstrb[0]);
    assign busy_s     = (state_r != ST_IDLE) || seg_valid_r;

    assign value_next_s = {bus.busin_wstrb[1] ? bus.busin_wdata[15:8] : value_r[15:8],
                           bus.busin_wstrb[0] ? bus.busin_wdata[7:0]  : value_r[7:0]};

    assign bcd_adj_s = {add3(bcd_r[19:16]), add3(bcd_r[15:12]), add3(bcd_r[11:8]),
                        add3(bcd_r[7:4]), add3(bcd_r[3:0])};

`ifdef SSEG_ENC_LZB_EN
    assign lzb_en_s = lzb_r;
`else
    assign lzb_en_s = 1'b0;
`endif
    assign ctrl_s = {lzb_en_s, dp_r};

    // Segment word candidate built from the finished BCD digits and the live CTRL value.
    always_comb begin
        seg_next_s = 32'h0000_0000;
        ovf_next_s = (bcd_r[19:16] != 4'd0);
        blank_s[3] = lzb_en_s && (bcd_r[15:12] == 4'd0);
        blank_s[2] = blank_s[3] && (bcd_r[11:8] == 4'd0);
        blank_s[1] = blank_s[2] && (bcd_r[7:4] == 4'd0);
        blank_s[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            seg_next_s[8*n +: 8] = encode_byte(bcd_r[4*n +: 4], ovf_next_s, blank_s[n], dp_r[n]);
        end
    end

    // Register read mux; reads return zero unless a read request is on the bus.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (is_read_s) begin
            case (bus.busin_addr[3:2])
                REG_VALUE:  rdata_s = {16'h0000, value_r};
                REG_STATUS: rdata_s = {30'h0000_0000, ovf_r, busy_s};
                REG_CTRL:   rdata_s = {27'h000_0000, ctrl_s};
                REG_SEG:    rdata_s = seg_word_r;
                default:    rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Software-visible VALUE and CTRL registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_r <= 16'h0000;
            dp_r    <= 4'h0;
`ifdef SSEG_ENC_LZB_EN
            lzb_r   <= 1'b0;
`endif
        end else begin
            if (wr_value_s) begin
                value_r <= value_next_s;
            end
            if (wr_ctrl_s) begin
                dp_r  <= bus.busin_wdata[3:0];
`ifdef SSEG_ENC_LZB_EN
                lzb_r <= bus.busin_wdata[4];
`endif
            end
        end
    end

    // Conversion FSM; a start always wins, so a VALUE write mid-run discards the run in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            bin_r       <= 16'h0000;
            bcd_r       <= 20'h0_0000;
            ovf_r       <= 1'b0;
            seg_word_r  <= 32'hFFFF_FFFF;
            seg_valid_r <= 1'b0;
        end else begin
            seg_valid_r <= 1'b0;
            if (start_s) begin
                state_r <= ST_SHIFT;
                cnt_r   <= 5'd0;
                bin_r   <= value_next_s;
                bcd_r   <= 20'h0_0000;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_SHIFT: begin
                        bcd_r <= {bcd_adj_s[18:0], bin_r[15]};
                        bin_r <= {bin_r[14:0], 1'b0};
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == 5'd15) begin
                            state_r <= ST_ENCODE;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end
                    ST_ENCODE: begin
                        seg_word_r  <= seg_next_s;
                        ovf_r       <= ovf_next_s;
                        seg_valid_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign seg_word          = seg_word_r;
    assign seg_valid         = seg_valid_r;
    assign bus.busout_ready  = bus.busin_valid;
    assign bus.busout_rdata  = rdata_s;

    assign unused_s = ^{bus.busin_addr[31:4], bus.busin_addr[1:0], bus.busin_wdata[31:16],
                        bus.busin_wstrb[3:2], bcd_adj_s[19], CLK_HZ[0]};

endmodule

// File: tb/tb_pico_sseg_encoder.sv
// Directed self-checking bench for pico_sseg_encoder; expectations follow SSEG_ENC_LZB_EN.
module tb_pico_sseg_encoder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] seg_word;
    logic        seg_valid;
    int          errors = 0;
    int          checks = 0;

    pico_sseg_bus_if bus_if ();

    pico_sseg_encoder #(.CLK_HZ(50_000_000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus_if),
        .seg_word  (seg_word),
        .seg_valid (seg_valid)
    );

    always #5 clk = ~clk;

`ifdef SSEG_ENC_LZB_EN
    localparam logic [31:0] EXP_CTRL14 = 32'h0000_0014;
    localparam logic [31:0] EXP_42_M4  = 32'hFF7F_99A4;
    localparam logic [31:0] EXP_42_M9  = 32'h7FFF_9924;
    localparam logic [31:0] EXP_0_M9   = 32'h7FFF_FF40;
`else
    localparam logic [31:0] EXP_CTRL14 = 32'h0000_0004;
    localparam logic [31:0] EXP_42_M4  = 32'hC040_99A4;
    localparam logic [31:0] EXP_42_M9  = 32'h40C0_9924;
    localparam logic [31:0] EXP_0_M9   = 32'h40C0_C040;
`endif

    task automatic bus_idle();
        bus_if.busin_valid = 1'b0;
        bus_if.busin_addr  = 32'h0;
        bus_if.busin_wdata = 32'h0;
        bus_if.busin_wstrb = 4'h0;
    endtask

    // Drives at the next falling edge; returns at the falling edge after the accepting edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        bus_if.busin_valid = 1'b1;
        bus_if.busin_addr  = addr;
        bus_if.busin_wdata = data;
        bus_if.busin_wstrb = strb;
        @(negedge clk);
        bus_idle();
    endtask

    // Combinational read inside the current low phase; consumes no clock edge.
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
        bus_if.busin_valid = 1'b1;
        bus_if.busin_addr  = addr;
        bus_if.busin_wstrb = 4'h0;
        #1;
        d = bus_if.busout_rdata;
        bus_idle();
    endtask

    task automatic wait_pulse(output int n, output bit busy_ok);
        logic [31:0] st;
        n = 0;
        busy_ok = 1'b1;
        while (1) begin
            bus_read(32'h4, st);
            if (st[0] !== 1'b1) busy_ok = 1'b0;
            if (seg_valid === 1'b1 || n >= 40) break;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_pulses(input int cycles, output int p);
        p = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (seg_valid === 1'b1) p++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int p;
        bus_idle();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        checks++; if (seg_word !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_seg_word: got %h expected ffffffff", seg_word); end
        checks++; if (bus_if.busout_ready !== 1'b0 || bus_if.busout_rdata !== 32'h0) begin errors++; $display("FAIL idle_bus: ready=%b rdata=%h expected 0 and 0", bus_if.busout_ready, bus_if.busout_rdata); end
        bus_read(32'hC, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_seg_read: got %h expected ffffffff", d); end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", d); end
        bus_read(32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", d); end
        bus_read(32'h8, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        count_pulses(20, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", p); end
    endtask

    task automatic test_convert(input logic [15:0] val, input logic [31:0] exp_seg, input logic [31:0] exp_status);
        int n;
        bit bok;
        logic [31:0] d;
        bus_write(32'h0, {16'hDEAD, val}, 4'b0011);
        wait_pulse(n, bok);
        checks++; if (n !== 17) begin errors++; $display("FAIL latency_%0d: got %0d expected 17", val, n); end
        checks++; if (!bok) begin errors++; $display("FAIL busy_%0d: got busy low expected high during conversion", val); end
        checks++; if (seg_word !== exp_seg) begin errors++; $display("FAIL seg_%0d: got %h expected %h", val, seg_word, exp_seg); end
        @(negedge clk);
        checks++; if (seg_valid !== 1'b0) begin errors++; $display("FAIL pulse_width_%0d: got %b expected 0", val, seg_valid); end
        bus_read(32'h4, d);
        checks++; if (d !== exp_status) begin errors++; $display("FAIL status_%0d: got %h expected %h", val, d, exp_status); end
        bus_read(32'h0, d);
        checks++; if (d !== {16'h0, val}) begin errors++; $display("FAIL value_rd_%0d: got %h expected %h", val, d, val); end
    endtask

    task automatic test_byte_strobes();
        int p;
        logic [31:0] d;
        bus_write(32'h0, 32'hABCD_0063, 4'b0001);
        count_pulses(17, p);
        checks++; if (p !== 1 || seg_word !== 32'hC0C0_9090) begin errors++; $display("FAIL low_byte_write: pulses=%0d seg=%h expected 1 and c0c09090", p, seg_word); end
        bus_write(32'hF000_0000, 32'hFFFF_1234, 4'b1100);
        bus_write(32'hC, 32'h0, 4'b1111);
        bus_write(32'h4, 32'hFFFF_FFFF, 4'b1111);
        count_pulses(20, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL ignored_writes_pulse: got %0d expected 0", p); end
        bus_read(32'h8000_0003, d);
        checks++; if (d !== 32'h0000_0063) begin errors++; $display("FAIL upper_strb_value: got %h expected 00000063", d); end
        bus_read(32'hC, d);
        checks++; if (d !== 32'hC0C0_9090) begin errors++; $display("FAIL seg_ro: got %h expected c0c09090", d); end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL status_ro: got %h expected 0", d); end
    endtask

    task automatic test_back_to_back(input int gap, input logic [15:0] first, input logic [15:0] second,
                                     input logic [31:0] exp_seg);
        int n;
        int p_early;
        int p_late;
        bit bok;
        bus_write(32'h0, {16'h0, first}, 4'b0011);
        count_pulses(gap - 2, p_early);
        bus_write(32'h0, {16'h0, second}, 4'b0011);
        wait_pulse(n, bok);
        checks++; if (p_early !== 0 || n !== 17) begin errors++; $display("FAIL restart_gap%0d: early=%0d latency=%0d expected 0 and 17", gap, p_early, n); end
        checks++; if (seg_word !== exp_seg || !bok) begin errors++; $display("FAIL restart_seg_gap%0d: got %h busy_ok=%0d expected %h", gap, seg_word, bok, exp_seg); end
        count_pulses(25, p_late);
        checks++; if (p_late !== 0) begin errors++; $display("FAIL restart_extra_pulse_gap%0d: got %0d expected 0", gap, p_late); end
    endtask

    task automatic test_ctrl();
        int p;
        logic [31:0] d;
        bus_write(32'h8, 32'hFFFF_FF14, 4'b0001);
        count_pulses(20, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL ctrl_no_start: got %0d expected 0", p); end
        bus_read(32'h8, d);
        checks++; if (d !== EXP_CTRL14) begin errors++; $display("FAIL ctrl_read: got %h expected %h", d, EXP_CTRL14); end
        test_convert(16'd42, EXP_42_M4, 32'h0);
        bus_write(32'h8, 32'h0000_0019, 4'b0001);
        test_convert(16'd42, EXP_42_M9, 32'h0);
        test_convert(16'd65535, 32'h3FBF_BF3F, 32'h2);
        test_convert(16'd0, EXP_0_M9, 32'h0);
    endtask

    task automatic test_reset_mid_shift();
        int p;
        logic [31:0] d;
        bus_write(32'h0, 32'h0000_162E, 4'b0011);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (seg_word !== 32'hFFFF_FFFF || seg_valid !== 1'b0) begin errors++; $display("FAIL midreset_outputs: seg=%h valid=%b expected ffffffff 0", seg_word, seg_valid); end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h expected 0", d); end
        bus_read(32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_value: got %h expected 0", d); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        count_pulses(30, p);
        checks++; if (p !== 0 || seg_word !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_after: pulses=%0d seg=%h expected 0 ffffffff", p, seg_word); end
    endtask

    initial begin
        test_reset();
        test_convert(16'd1234, 32'hF9A4_B099, 32'h0);
        test_convert(16'd10000, 32'hBFBF_BFBF, 32'h2);
        test_convert(16'd0, 32'hC0C0_C0C0, 32'h0);
        test_byte_strobes();
        test_back_to_back(5, 16'd1111, 16'd9, 32'hC0C0_C090);
        test_back_to_back(17, 16'd1111, 16'd7, 32'hC0C0_C0F8);
        test_ctrl();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
